// File: rtl/axi_m_arbiter.sv
// rtl/axi_m_arbiter.sv - N-master AR/AW/W request arbiter with W-order queue.
// Build option: define AXI_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
module axi_m_arbiter #(
    parameter int NUM_M    = 4,
    parameter int AR_W     = 49,
    parameter int AW_W     = 49,
    parameter int W_W      = 37,
    parameter int WQ_DEPTH = 4,
    localparam int SEL_W   = $clog2(NUM_M),
    localparam int PTR_W   = $clog2(WQ_DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                    AXI_CLK_i,
    input  logic                    AXI_RST_i,
    input  logic [NUM_M-1:0]        M_AR_VALID_i,
    input  logic [NUM_M*AR_W-1:0]   M_AR_DATA_i,
    output logic [NUM_M-1:0]        M_AR_READY_o,
    input  logic [NUM_M-1:0]        M_AW_VALID_i,
    input  logic [NUM_M*AW_W-1:0]   M_AW_DATA_i,
    output logic [NUM_M-1:0]        M_AW_READY_o,
    input  logic [NUM_M-1:0]        M_W_VALID_i,
    input  logic [NUM_M*W_W-1:0]    M_W_DATA_i,
    input  logic [NUM_M-1:0]        M_W_LAST_i,
    output logic [NUM_M-1:0]        M_W_READY_o,
    output logic                    S_AR_VALID_o,
    output logic [AR_W-1:0]         S_AR_DATA_o,
    output logic [SEL_W-1:0]        S_AR_SEL_o,
    input  logic                    S_AR_READY_i,
    output logic                    S_AW_VALID_o,
    output logic [AW_W-1:0]         S_AW_DATA_o,
    output logic [SEL_W-1:0]        S_AW_SEL_o,
    input  logic                    S_AW_READY_i,
    output logic                    S_W_VALID_o,
    output logic [W_W-1:0]          S_W_DATA_o,
    output logic                    S_W_LAST_o,
    output logic [SEL_W-1:0]        S_W_SEL_o,
    input  logic                    S_W_READY_i,
    output logic [CNT_W-1:0]        WQ_COUNT_o
);

    localparam logic [NUM_M-1:0] ONE = NUM_M'(1);

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // Search starts at ptr; the lowest offset from ptr with a request wins.
    function automatic logic [SEL_W-1:0] pick(input logic [NUM_M-1:0] req,
                                              input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        int k;
        idx = '0;
        for (int j = NUM_M - 1; j >= 0; j--) begin
            k = (int'(ptr) + j) % NUM_M;
            if (req[k]) idx = SEL_W'(k);
        end
        return idx;
    endfunction

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] k);
        return (k == SEL_W'(NUM_M - 1)) ? '0 : k + 1'b1;
    endfunction
`else
    function automatic logic [SEL_W-1:0] pick(input logic [NUM_M-1:0] req);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int j = NUM_M - 1; j >= 0; j--) begin
            if (req[j]) idx = SEL_W'(j);
        end
        return idx;
    endfunction
`endif

    logic [SEL_W-1:0] ar_idx;
    logic [SEL_W-1:0] aw_idx;
    logic             ar_acc;
    logic             aw_acc;
    logic             w_acc;
    logic             ar_gnt;
    logic             aw_gnt;
    logic             w_fire;

    logic [SEL_W-1:0] wq_mem [WQ_DEPTH];
    logic [PTR_W-1:0] wq_wr_ptr;
    logic [PTR_W-1:0] wq_rd_ptr;
    logic [CNT_W-1:0] wq_count;
    logic             wq_empty;
    logic             wq_full;
    logic             wq_push;
    logic             wq_pop;
    logic [SEL_W-1:0] wq_head;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ar_ptr;
    logic [SEL_W-1:0] aw_ptr;

    assign ar_idx = pick(M_AR_VALID_i, ar_ptr);
    assign aw_idx = pick(M_AW_VALID_i, aw_ptr);

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            ar_ptr <= '0;
            aw_ptr <= '0;
        end else begin
            if (ar_gnt) ar_ptr <= next_ptr(ar_idx);
            if (aw_gnt) aw_ptr <= next_ptr(aw_idx);
        end
    end
`else
    assign ar_idx = pick(M_AR_VALID_i);
    assign aw_idx = pick(M_AW_VALID_i);
`endif

    assign wq_empty = (wq_count == '0);
    assign wq_full  = (wq_count == CNT_W'(WQ_DEPTH));
    assign wq_head  = wq_mem[wq_rd_ptr];

    assign ar_acc = !S_AR_VALID_o || S_AR_READY_i;
    assign aw_acc = !S_AW_VALID_o || S_AW_READY_i;
    assign w_acc  = !S_W_VALID_o  || S_W_READY_i;

    // W routing only follows the queue head, so a master without a queued AW never gets ready.
    assign M_W_READY_o = (!wq_empty && w_acc) ? ((ONE << wq_head) & M_W_VALID_i) : '0;
    assign w_fire      = |M_W_READY_o;
    assign wq_pop      = w_fire && M_W_LAST_i[wq_head];

    // A same-cycle pop frees the head entry, so a full queue can still take a push.
    assign ar_gnt = ar_acc && |M_AR_VALID_i;
    assign aw_gnt = aw_acc && |M_AW_VALID_i && (!wq_full || wq_pop);
    assign wq_push = aw_gnt;

    assign M_AR_READY_o = ar_gnt ? (ONE << ar_idx) : '0;
    assign M_AW_READY_o = aw_gnt ? (ONE << aw_idx) : '0;

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            S_AR_VALID_o <= 1'b0;
            S_AR_DATA_o  <= '0;
            S_AR_SEL_o   <= '0;
        end else if (ar_gnt) begin
            S_AR_VALID_o <= 1'b1;
            S_AR_DATA_o  <= M_AR_DATA_i[ar_idx*AR_W +: AR_W];
            S_AR_SEL_o   <= ar_idx;
        end else if (S_AR_READY_i) begin
            S_AR_VALID_o <= 1'b0;
        end
    end

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            S_AW_VALID_o <= 1'b0;
            S_AW_DATA_o  <= '0;
            S_AW_SEL_o   <= '0;
        end else if (aw_gnt) begin
            S_AW_VALID_o <= 1'b1;
            S_AW_DATA_o  <= M_AW_DATA_i[aw_idx*AW_W +: AW_W];
            S_AW_SEL_o   <= aw_idx;
        end else if (S_AW_READY_i) begin
            S_AW_VALID_o <= 1'b0;
        end
    end

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            S_W_VALID_o <= 1'b0;
            S_W_DATA_o  <= '0;
            S_W_LAST_o  <= 1'b0;
            S_W_SEL_o   <= '0;
        end else if (w_fire) begin
            S_W_VALID_o <= 1'b1;
            S_W_DATA_o  <= M_W_DATA_i[wq_head*W_W +: W_W];
            S_W_LAST_o  <= M_W_LAST_i[wq_head];
            S_W_SEL_o   <= wq_head;
        end else if (S_W_READY_i) begin
            S_W_VALID_o <= 1'b0;
        end
    end

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            for (int i = 0; i < WQ_DEPTH; i++) wq_mem[i] <= '0;
            wq_wr_ptr <= '0;
            wq_rd_ptr <= '0;
            wq_count  <= '0;
        end else begin
            if (wq_push) begin
                wq_mem[wq_wr_ptr] <= aw_idx;
                wq_wr_ptr         <= wq_wr_ptr + 1'b1;
            end
            if (wq_pop) wq_rd_ptr <= wq_rd_ptr + 1'b1;
            case ({wq_push, wq_pop})
                2'b10:   wq_count <= wq_count + 1'b1;
                2'b01:   wq_count <= wq_count - 1'b1;
                default: wq_count <= wq_count;
            endcase
        end
    end

    assign WQ_COUNT_o = wq_count;

endmodule

// File: doc/axi_m_arbiter.md
# axi_m_arbiter

Parametrised N-master arbiter for the AXI master-side request channels (AR, AW, W) in the crossbar master interface, replacing the fixed two-master per-channel arbiters. Each channel has one registered output slice. The W channel is locked to the AW grant order by an internal order queue, so write data never interleaves between masters. One clock domain; downstream clock crossing is handled by the existing async FIFOs.

## Interface
- NUM_M, 4: number of masters; legal range 2–8. SEL_W = $clog2(NUM_M).
- AR_W, 49: AR payload width.
- AW_W, 49: AW payload width.
- W_W, 37: W payload width, excluding the WLAST bit.
- WQ_DEPTH, 4: W-order queue depth, power of 2, ≥2.

- AXI_CLK_i  in  1  channel clock; all state is rising-edge.
- AXI_RST_i  in  1  reset, asynchronous assert, active-low (low = in reset).
- M_AR_VALID_i  in  NUM_M  per-master AR request.
- M_AR_DATA_i  in  NUM_M*AR_W  AR payloads; master k occupies [k*AR_W +: AR_W].
- M_AR_READY_o  out  NUM_M  one-hot grant/accept.
- M_AW_VALID_i, M_AW_DATA_i, M_AW_READY_o: same structure as the AR ports, using AW_W.
- M_W_VALID_i  in  NUM_M; M_W_DATA_i  in  NUM_M*W_W; M_W_LAST_i  in  NUM_M; M_W_READY_o  out  NUM_M.
- S_AR_VALID_o  out  1; S_AR_DATA_o  out  AR_W; S_AR_SEL_o  out  SEL_W (winning master index); S_AR_READY_i  in  1.
- S_AW_VALID_o, S_AW_DATA_o, S_AW_SEL_o, S_AW_READY_i: same structure as the AR slave ports.
- S_W_VALID_o  out  1; S_W_DATA_o  out  W_W; S_W_LAST_o  out  1; S_W_SEL_o  out  SEL_W; S_W_READY_i  in  1.
- WQ_COUNT_o  out  $clog2(WQ_DEPTH)+1  W-order queue occupancy.

## Operation
- Reset values: all S_*_VALID_o = 0; S_*_DATA_o, S_*_SEL_o and S_W_LAST_o = 0; M_*_READY_o = 0; WQ_COUNT_o = 0. All priority pointers = 0. Queue pointers = 0.
- Slice accept condition per channel: acc = !S_x_VALID_o || S_x_READY_i. Back-to-back throughput is one beat per cycle.
- AR arbitration: when acc is high and any M_AR_VALID_i bit is set, pick winner k. M_AR_READY_o[k] = 1 in the same cycle, combinationally. On the next edge, load payload and k into the slice and set valid.
- AW arbitration: identical to AR, with one extra gate: grant only when the W-order queue is not full. A successful AW grant pushes k into the queue.
- W routing: no arbitration. Head h is the queue head. When the queue is non-empty and acc is high, M_W_READY_o[h] = M_W_VALID_i[h]; all other M_W_READY_o bits = 0.
- A W beat accepted with M_W_LAST_i[h] = 1 pops the queue on the same edge. If the queue is empty, all M_W_READY_o = 0.
- Queue boundary cases:
  - Push and pop in the same cycle: count unchanged; allowed even when the queue is full, because the pop frees the entry first.
  - Queue full with no pop: AW grant is blocked.
  - Pointers wrap modulo WQ_DEPTH.
- Write-before-address: W data from a master that is not at the queue head is held (ready = 0), including masters that have no AW queued.
- Pointer update (round-robin mode): after a grant to k, that channel's pointer becomes (k+1) mod NUM_M. Search order starts at the pointer.
- Reset mid-operation: every slice is cleared immediately and the queue is emptied. Beats in flight are dropped, and masters must re-issue them.

## Timing
- Request-to-S_VALID latency: 1 cycle. Grant (M_READY) is in the same cycle as the request.
- S_*_DATA_o, S_*_SEL_o and S_*_VALID_o are registered. M_*_READY_o are combinational from the inputs and state.
- AW-to-first-W latency through the queue: the first W beat is routable the cycle after the AW grant edge.
- S_x_DATA_o is held stable while S_x_VALID_o && !S_x_READY_i.

## Configuration
- AXI_ARB_ROUND_ROBIN_EN defined: round-robin with per-channel pointers, as described in Operation.
- AXI_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins. Pointers are not implemented.

## Test plan
- Reset, then AR from masters 0 and 2 simultaneously, with S_AR_READY_i held at 1. Required: round-robin build grants 0 then 2, with S_AR_SEL_o = 0 then 2 on consecutive cycles. Fixed-priority build grants 0 first.
- All 4 masters hold AR valid continuously, with S_AR_READY_i = 1. Required: round-robin grant sequence 0,1,2,3,0; M_AR_READY_o is one-hot every cycle.
- S_AR_READY_i = 0 for 3 cycles with a loaded slice. Required: S_AR_DATA_o stable, all M_AR_READY_o = 0, no beat lost or duplicated.
- AW from master 1 (2-beat burst), then AW from master 3 (1 beat); master 3 presents W first. Required: master 3 is held; S_W_SEL_o sequence is 1,1,3; S_W_LAST_o = 1 on beats 2 and 3.
- Issue 4 AWs with no W traffic, WQ_DEPTH = 4. Required: WQ_COUNT_o = 4 and a 5th AW is blocked. Then a W with WLAST = 1 and a new AW arrive in the same cycle: count stays 4 and the AW is granted.
- Assert reset (low) with 2 queued AWs and a loaded W slice. Required: all S_*_VALID_o = 0 immediately and WQ_COUNT_o = 0.
